// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply and restoring
// divide on operand magnitudes, sign correction applied in a final FIX cycle.
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo honoured here
// CALC  | one shift-add / shift-subtract step per edge, WIDTH steps
// FIX   | sign-correct the result and write hi/lo
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             rdHiLo,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, b_q, b_d;
  logic             is_div_q, is_div_d, qneg_q, qneg_d, rneg_q, rneg_d, div0_q, div0_d;

  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_comb begin
    // op[0]=0 selects the signed variants (MULT, DIV)
    sign_a    = ~op[0] & srcA[WIDTH-1];
    sign_b    = ~op[0] & srcB[WIDTH-1];
    mag_a     = sign_a ? -srcA : srcA;
    mag_b     = sign_b ? -srcB : srcB;
    mul_sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {rem_q, quo_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, b_q};
    prod_fix  = qneg_q ? -{rem_q, quo_q} : {rem_q, quo_q};
    quo_fix   = qneg_q ? -quo_q : quo_q;
    rem_fix   = rneg_q ? -rem_q : rem_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = CALC;
          cnt_d    = '0;
          rem_d    = '0;
          quo_d    = mag_a;
          b_d      = mag_b;
          is_div_d = op[1];
          qneg_d   = sign_a ^ sign_b;
          rneg_d   = sign_a;
          div0_d   = op[1] & (srcB == '0);
        end else begin
          if (mthi) hi_d = srcA;
          if (mtlo) lo_d = srcA;
        end
      end
      CALC: begin
        if (cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          if (is_div_q) begin
            // restoring step: keep the difference only when it did not go negative
            if (!div_diff[WIDTH+1]) begin
              rem_d = div_diff[WIDTH-1:0];
              quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_d = div_shift[WIDTH-1:0];
              quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            rem_d = mul_sum[WIDTH:1];
            quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
          end
          if (cnt_q == CNT_LAST) begin
            state_d = FIX;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!cancel) begin
          if (is_div_q) begin
            // a zero divisor leaves the dividend magnitude in rem, so hi recovers srcA
            lo_d = div0_q ? '1 : quo_fix;
            hi_d = rem_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q != IDLE);
  assign stall = busy & (start | rdHiLo | mthi | mtlo);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: stimulus pushes expected hi/lo/busy-length,
// a monitor pops and compares whenever busy falls.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] srcA = '0, srcB = '0;
  logic        mthi = 1'b0, mtlo = 1'b0, rdHiLo = 1'b0, cancel = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, stall;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .mthi(mthi), .mtlo(mtlo), .rdHiLo(rdHiLo), .cancel(cancel),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // monitor: count busy cycles and compare on each busy fall
  logic busy_prev = 1'b0;
  int   bcnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_prev = 1'b0;
      bcnt      = 0;
    end else begin
      if (busy) bcnt++;
      if (busy_prev && !busy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("hi", hi, e.hi);
          check("lo", lo, e.lo);
          check("busy_cycles", bcnt, e.lat);
        end
        bcnt = 0;
      end
      busy_prev = busy;
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int elat,
                        input int cancel_at, input int rd_at, input int restart_at,
                        input logic with_mtlo);
    exp_t e;
    int   cyc;
    e.hi = ehi; e.lo = elo; e.lat = elat;
    exp_q.push_back(e);
    op = o; srcA = a; srcB = b; start = 1'b1; mtlo = with_mtlo;
    step();
    start = 1'b0; mtlo = 1'b0;
    srcA = 32'hDEAD_BEEF; srcB = 32'h0BAD_F00D;
    cyc = 1;
    while (cyc < 60) begin
      if (cyc == rd_at + 1) begin rdHiLo = 1'b0; #1 check("stall_rd_low", stall, 1'b0); end
      if (cyc == restart_at + 1) start = 1'b0;
      if (cyc == cancel_at + 1) cancel = 1'b0;
      if (!busy) break;
      if (cyc == rd_at) begin rdHiLo = 1'b1; #1 check("stall_rd_high", stall, 1'b1); end
      if (cyc == restart_at) begin
        op = MULTU; srcA = 32'd3; srcB = 32'd3; start = 1'b1;
        #1 check("stall_restart", stall, 1'b1);
      end
      if (cyc == cancel_at) cancel = 1'b1;
      step();
      cyc++;
    end
    if (cyc >= 60) check("timeout", 32'd1, 32'd0);
    start = 1'b0; rdHiLo = 1'b0; cancel = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    step();

    rdHiLo = 1'b1; mthi = 1'b1; #1 check("stall_idle", stall, 1'b0);
    rdHiLo = 1'b0; mthi = 1'b0;

    srcA = 32'h1234; mthi = 1'b1; step(); mthi = 1'b0; #1;
    check("mthi_hi", hi, 32'h1234);
    check("mthi_lo", lo, 32'h0);
    srcA = 32'h55; mtlo = 1'b1; step(); mtlo = 1'b0; #1;
    check("mtlo_lo", lo, 32'h55);
    check("mtlo_hi", hi, 32'h1234);

    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 0, 0, 0, 1'b0);
    run_op(MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 0, 0, 0, 1'b0);
    run_op(DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 0, 0, 0, 1'b0);
    run_op(DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33, 0, 0, 0, 1'b0);
    run_op(DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 33, 0, 0, 0, 1'b0);
    run_op(DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 33, 0, 0, 0, 1'b0);
    run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, 0, 0, 0, 1'b0);
    run_op(DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 33, 0, 0, 0, 1'b0);
    run_op(DIVU,  32'd1000,      32'd7,         32'd6,         32'h0000_008E, 33, 0, 5, 10, 1'b0);
    run_op(MULTU, 32'd6,         32'd7,         32'd0,         32'd42,        33, 0, 0, 0, 1'b1);
    run_op(MULT,  32'd5,         32'd5,         32'd0,         32'd42,        20, 20, 0, 0, 1'b0);
    run_op(MULT,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 33, 0, 0, 0, 1'b0);
    run_op(MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33, 0, 0, 0, 1'b0);

    // asynchronous reset in the middle of CALC
    op = MULT; srcA = 32'd3; srcB = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    check("busy_mid_calc", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_hi", hi, 32'h0);
    check("rst_mid_lo", lo, 32'h0);
    check("rst_mid_busy", busy, 1'b0);
    step();
    rst_n = 1'b1;
    step();

    run_op(MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 33, 0, 0, 0, 1'b0);
    repeat (2) step();
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
